// File: rtl/fp32_norm_round.sv
// fp32_norm_round: normalise, round-to-nearest-even and pack stage of the
// SFU FP32 adder, built as a 3-stage valid/ready pipeline.
module fp32_norm_round #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic [EXP_W-1:0]      in_exp,
    input  logic [MANT_W+4:0]     in_mant,
    input  logic [4:0]            in_lz,
    input  logic                  in_sticky,
    input  logic                  in_bypass,
    input  logic [EXP_W+MANT_W:0] in_bypass_val,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+MANT_W:0] out_result,
    output logic [2:0]            out_flags
);
    localparam int W  = MANT_W + 5;
    localparam int XW = EXP_W + 2;
    localparam int RW = EXP_W + MANT_W + 1;
    localparam logic signed [XW-1:0] E_ONE = XW'(1);
    localparam logic signed [XW-1:0] E_MAX = XW'((1 << EXP_W) - 1);

    logic en;
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    logic                 s1_valid, s1_sign, s1_sticky, s1_bypass;
    logic [W-2:0]         s1_mant;
    logic signed [XW-1:0] s1_exp;
    logic [RW-1:0]        s1_bval;

    logic                 s2_valid, s2_sign, s2_norm, s2_inexact;
    logic                 s2_zero, s2_bypass;
    logic signed [XW-1:0] s2_exp;
    logic [MANT_W-1:0]    s2_frac;
    logic [RW-1:0]        s2_bval;

    logic [XW-1:0]        sh_raw, sh_lim, sh;
    logic [W-2:0]         c1_mant;
    logic signed [XW-1:0] c1_exp;
    logic                 c1_sticky;

    // Coarse shift: the shift never takes the exponent below 1.
    always_comb begin
        sh_raw    = (in_lz == 5'd0) ? '0 : XW'(in_lz) - XW'(1);
        sh_lim    = XW'(in_exp) - XW'(1);
        sh        = (sh_raw > sh_lim) ? sh_lim : sh_raw;
        c1_sticky = in_sticky;
        if (in_mant[W-1]) begin
            c1_mant   = in_mant[W-1:1];
            c1_sticky = in_sticky | in_mant[0];
            c1_exp    = $signed(XW'(in_exp) + XW'(1));
        end else begin
            c1_mant = in_mant[W-2:0] << sh;
            c1_exp  = $signed(XW'(in_exp) - sh);
        end
    end

    logic [W-2:0]         m2;
    logic signed [XW-1:0] e2;
    logic                 g, r, s, lsb, inc, carry;
    logic [MANT_W+1:0]    sum;

    // One-bit fix-up for an LZA under-count, then round at bit 3.
    always_comb begin
        m2 = s1_mant;
        e2 = s1_exp;
        if (!s1_mant[W-2] && s1_mant != '0 && s1_exp > E_ONE) begin
            m2 = s1_mant << 1;
            e2 = s1_exp - E_ONE;
        end
        lsb   = m2[3];
        g     = m2[2];
        r     = m2[1];
        s     = m2[0] | s1_sticky;
        inc   = g & (r | s | lsb);
        sum   = {1'b0, m2[W-2:3]} + {{(MANT_W+1){1'b0}}, inc};
        carry = sum[MANT_W+1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_bypass) begin
                out_result <= s2_bval;
                out_flags  <= 3'b000;
            end else if (s2_exp >= E_MAX) begin
                out_result <= {s2_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                out_flags  <= 3'b101;
            end else if (s2_zero) begin
                out_result <= '0;
                out_flags  <= 3'b000;
            end else begin
                out_result <= {s2_sign,
                               s2_norm ? s2_exp[EXP_W-1:0] : {EXP_W{1'b0}},
                               s2_frac};
                out_flags  <= {1'b0, ~s2_norm & s2_inexact, s2_inexact};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s1_sign    <= in_sign;
            s1_mant    <= c1_mant;
            s1_exp     <= c1_exp;
            s1_sticky  <= c1_sticky;
            s1_bypass  <= in_bypass;
            s1_bval    <= in_bypass_val;
            s2_sign    <= s1_sign;
            s2_exp     <= carry ? e2 + E_ONE : e2;
            s2_frac    <= carry ? '0 : sum[MANT_W-1:0];
            s2_norm    <= sum[MANT_W+1] | sum[MANT_W];
            s2_inexact <= g | r | s;
            s2_zero    <= (s1_mant == '0) && !s1_sticky;
            s2_bypass  <= s1_bypass;
            s2_bval    <= s1_bval;
        end
    end
endmodule

// File: tb/tb_fp32_norm_round.sv
// tb_fp32_norm_round: directed vectors plus randomized traffic checked
// against an arithmetic reference model of the normalise/round stage.
module tb_fp32_norm_round;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_sign, in_sticky, in_bypass;
    logic [7:0]  in_exp;
    logic [27:0] in_mant;
    logic [4:0]  in_lz;
    logic [31:0] in_bypass_val, out_result;
    logic        out_valid, out_ready;
    logic [2:0]  out_flags;

    int checks = 0;
    int failures = 0;

    logic        mv [3];
    logic [34:0] md [3];
    logic        acc_m;

    fp32_norm_round #(.EXP_W(8), .MANT_W(23)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .in_lz(in_lz), .in_sticky(in_sticky),
        .in_bypass(in_bypass), .in_bypass_val(in_bypass_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    // Directed vectors: sign, exp, mant, lz, sticky, bypass, result, flags
    logic        v_sign [12] = '{0,0,0,0,0,0,1,0,0,1,0,0};
    logic [7:0]  v_exp  [12] = '{127,127,127,127,127,254,127,1,1,127,50,1};
    logic [27:0] v_mant [12] = '{28'h8000000, 28'h1000000, 28'h1000000,
                                 28'h4000004, 28'h400000C, 28'h8000000,
                                 28'h0000000, 28'h0000100, 28'h3FFFFFC,
                                 28'h4000000, 28'h4000000, 28'h0000104};
    logic [4:0]  v_lz   [12] = '{0,3,2,1,1,0,28,19,1,1,1,19};
    logic        v_stk  [12] = '{0,0,0,0,0,0,0,0,0,1,0,0};
    logic        v_byp  [12] = '{0,0,0,0,0,0,0,0,0,0,1,0};
    logic [31:0] v_res  [12] = '{32'h40000000, 32'h3E800000, 32'h3E800000,
                                 32'h3F800000, 32'h3F800002, 32'h7F800000,
                                 32'h00000000, 32'h00000020, 32'h00800000,
                                 32'hBF800000, 32'h7FC00001, 32'h00000020};
    logic [2:0]  v_flg  [12] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001,
                                 3'b101, 3'b000, 3'b000, 3'b001, 3'b001,
                                 3'b000, 3'b011};

    // Value-level model: {flags, result} for one beat.
    function automatic logic [34:0] ref_model(
        input logic sg, input logic [7:0] ex, input logic [27:0] mt,
        input logic [4:0] lz, input logic stk, input logic byp,
        input logic [31:0] bv);
        longint m, q;
        int     e, sh;
        bit     st, g, r, s, lsb, inc, inx, nrm;
        logic [7:0]  ef;
        logic [22:0] ff;
        if (byp) return {3'b000, bv};
        m  = longint'(mt);
        e  = int'(ex);
        st = stk;
        if (m >= 134217728) begin
            st = st | (m % 2 == 1);
            m  = m / 2;
            e  = e + 1;
        end else begin
            sh = (lz == 0) ? 0 : int'(lz) - 1;
            if (sh > e - 1) sh = e - 1;
            for (int k = 0; k < sh; k++) m = m * 2;
            e = e - sh;
        end
        if (m < 67108864 && m != 0 && e > 1) begin
            m = m * 2;
            e = e - 1;
        end
        if (e >= 255) return {3'b101, sg, 8'hFF, 23'h0};
        if (m == 0 && !st) return 35'h0;
        lsb = (m / 8) % 2 == 1;
        g   = (m / 4) % 2 == 1;
        r   = (m / 2) % 2 == 1;
        s   = (m % 2 == 1) || st;
        inc = g && (r || s || lsb);
        inx = g || r || s;
        q   = m / 8 + (inc ? 1 : 0);
        if (q >= 16777216) begin
            q = q / 2;
            e = e + 1;
        end
        if (e >= 255) return {3'b101, sg, 8'hFF, 23'h0};
        nrm = q >= 8388608;
        ef  = nrm ? 8'(e) : 8'h00;
        ff  = 23'(q % 8388608);
        return {1'b0, !nrm && inx, inx, sg, ef, ff};
    endfunction

    task automatic gen_beat();
        int w, tlz;
        logic [31:0] rv;
        w  = $urandom_range(0, 28);
        rv = $urandom;
        if (w == 0) in_mant = '0;
        else begin
            rv = rv >> (32 - w);
            rv[w-1] = 1'b1;
            in_mant = rv[27:0];
        end
        tlz = 28 - w;
        if (tlz > 0 && $urandom_range(0, 1) == 1) tlz = tlz - 1;
        in_lz = 5'(tlz);
        case ($urandom_range(0, 3))
            0: in_exp = 8'($urandom_range(1, 8));
            1: in_exp = 8'($urandom_range(240, 254));
            default: in_exp = 8'($urandom_range(1, 254));
        endcase
        in_sign       = 1'($urandom_range(0, 1));
        in_sticky     = ($urandom_range(0, 3) == 0);
        in_bypass     = ($urandom_range(0, 15) == 0);
        in_bypass_val = $urandom;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            mv[i] = 1'b0;
            md[i] = '0;
        end
    endtask

    // Advance the pipeline model with the current inputs, then clock.
    task automatic tick();
        logic en_m;
        en_m  = out_ready | !mv[2];
        acc_m = in_valid & en_m;
        if (en_m) begin
            mv[2] = mv[1]; md[2] = md[1];
            mv[1] = mv[0]; md[1] = md[0];
            mv[0] = in_valid;
            md[0] = ref_model(in_sign, in_exp, in_mant, in_lz,
                              in_sticky, in_bypass, in_bypass_val);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        clear_model();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (out_result !== 32'h0 || out_flags !== 3'b0) begin
            failures++;
            $display("FAIL reset_data got=%h/%b exp=0/000", out_result, out_flags);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
    endtask

    task automatic test_vectors();
        for (int i = 0; i < 12; i++) begin
            in_sign = v_sign[i]; in_exp = v_exp[i]; in_mant = v_mant[i];
            in_lz = v_lz[i]; in_sticky = v_stk[i]; in_bypass = v_byp[i];
            in_bypass_val = 32'h7FC00001;
            in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            for (int c = 1; c <= 3; c++) begin
                checks++;
                if (out_valid !== (c == 3)) begin
                    failures++;
                    $display("FAIL vec%0d latency cyc%0d valid got=%b", i, c, out_valid);
                end
                if (c < 3) begin
                    @(posedge clk);
                    #1;
                end
            end
            checks++;
            if (out_result !== v_res[i] || out_flags !== v_flg[i]) begin
                failures++;
                $display("FAIL vec%0d got=%h/%b exp=%h/%b", i,
                         out_result, out_flags, v_res[i], v_flg[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int sent, pops;
        bit need;
        flush();
        sent = 0; pops = 0; need = 1;
        for (int c = 1; c <= 20; c++) begin
            if (sent < 5) begin
                if (need) gen_beat();
                in_valid = 1'b1;
            end else in_valid = 1'b0;
            out_ready = !(c >= 4 && c <= 7);
            #1;
            checks++;
            if (in_ready !== (out_ready | !mv[2])) begin
                failures++;
                $display("FAIL bp_ready cyc%0d got=%b", c, in_ready);
            end
            checks++;
            if (out_valid !== mv[2]) begin
                failures++;
                $display("FAIL bp_valid cyc%0d got=%b exp=%b", c, out_valid, mv[2]);
            end
            if (mv[2]) begin
                checks++;
                if ({out_flags, out_result} !== md[2]) begin
                    failures++;
                    $display("FAIL bp_data cyc%0d got=%h exp=%h", c,
                             {out_flags, out_result}, md[2]);
                end
            end
            if (out_valid === 1'b1 && out_ready) pops++;
            tick();
            if (acc_m) sent++;
            need = acc_m;
        end
        checks++;
        if (pops != 5) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=5", pops);
        end
    endtask

    task automatic test_random();
        flush();
        for (int c = 0; c < 600; c++) begin
            gen_beat();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            checks++;
            if (in_ready !== (out_ready | !mv[2])) begin
                failures++;
                $display("FAIL rnd_ready cyc%0d got=%b", c, in_ready);
            end
            checks++;
            if (out_valid !== mv[2]) begin
                failures++;
                $display("FAIL rnd_valid cyc%0d got=%b exp=%b", c, out_valid, mv[2]);
            end
            if (mv[2]) begin
                checks++;
                if ({out_flags, out_result} !== md[2]) begin
                    failures++;
                    $display("FAIL rnd_data cyc%0d got=%h exp=%h", c,
                             {out_flags, out_result}, md[2]);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        int first;
        flush();
        for (int i = 0; i < 3; i++) begin
            gen_beat();
            in_valid = 1'b1;
            #1;
            tick();
        end
        checks++;
        if (out_valid !== mv[2]) begin
            failures++;
            $display("FAIL mid_inflight got=%b exp=%b", out_valid, mv[2]);
        end
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_flags !== 3'b0) begin
            failures++;
            $display("FAIL mid_reset got=%b %h %b exp=0", out_valid, out_result, out_flags);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        clear_model();
        first = -1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 4);
            if (c == 4) gen_beat();
            #1;
            if (out_valid === 1'b1 && first < 0) first = c;
            checks++;
            if (out_valid !== mv[2]) begin
                failures++;
                $display("FAIL mid_valid cyc%0d got=%b exp=%b", c, out_valid, mv[2]);
            end
            if (mv[2]) begin
                checks++;
                if ({out_flags, out_result} !== md[2]) begin
                    failures++;
                    $display("FAIL mid_data got=%h exp=%h", {out_flags, out_result}, md[2]);
                end
            end
            tick();
        end
        checks++;
        if (first != 7) begin
            failures++;
            $display("FAIL mid_latency got=%0d exp=7", first);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_sign = 1'b0; in_exp = 8'd1; in_mant = '0; in_lz = '0;
        in_sticky = 1'b0; in_bypass = 1'b0; in_bypass_val = '0;
        acc_m = 1'b0;
        clear_model();
        #2;
        test_reset();
        test_vectors();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
